// File: rtl/reg_writeback_pkg.sv
// Shared widths, constants and helpers for the register-file write-back front end.
package reg_writeback_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DEPTH_DEF  = 4;
  localparam int unsigned NUM_REGS   = 32;

  localparam logic [ADDR_W_DEF-1:0] REG_ZERO = '0;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/reg_writeback_if.sv
// ALU, LSU and register-file write-port signals of the write-back block.
interface reg_writeback_if
  import reg_writeback_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned CNT_W  = 3
);

  logic                alu_valid;
  logic [ADDR_W-1:0]   alu_addr;
  logic [DATA_W-1:0]   alu_data;
  logic                lsu_valid;
  logic                lsu_ready;
  logic [ADDR_W-1:0]   lsu_addr;
  logic [DATA_W-1:0]   lsu_data;
  logic                rf_we;
  logic [ADDR_W-1:0]   rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;
  logic [NUM_REGS-1:0] pend_mask;
  logic [CNT_W-1:0]    q_count;

  modport master (
    output alu_valid, alu_addr, alu_data, lsu_valid, lsu_addr, lsu_data,
    input  lsu_ready, rf_we, rf_waddr, rf_wdata, pend_mask, q_count
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, lsu_valid, lsu_addr, lsu_data,
    output lsu_ready, rf_we, rf_waddr, rf_wdata, pend_mask, q_count
  );

endinterface

// File: rtl/reg_writeback_wb_fifo.sv
// In-order LSU write queue: circular buffer with per-entry live bit, address kill
// and a registered one-hot OR of live destination registers.
module reg_writeback_wb_fifo
  import reg_writeback_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     push_kill,
  input  logic [ADDR_W-1:0]        push_addr,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  input  logic                     kill_en,
  input  logic [ADDR_W-1:0]        kill_addr,
  output logic                     empty,
  output logic                     head_live,
  output logic [ADDR_W-1:0]        head_addr,
  output logic [DATA_W-1:0]        head_data,
  output logic                     ready,
  output logic [clog2(DEPTH):0]    count,
  output logic [NUM_REGS-1:0]      live_mask
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]  valid_q, valid_n;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_n [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_n [DEPTH];
  logic [PTR_W-1:0]  head_q, head_n, tail_q, tail_n;
  logic [CNT_W-1:0]  count_n;
  logic [NUM_REGS-1:0] mask_n;
  logic              ready_n;

  assign empty     = (count == '0);
  assign head_live = valid_q[head_q];
  assign head_addr = addr_q[head_q];
  assign head_data = data_q[head_q];

  // Next queue state; kill and pop never coincide because the ALU owns the port.
  always_comb begin
    valid_n = valid_q;
    addr_n  = addr_q;
    data_n  = data_q;
    head_n  = head_q;
    tail_n  = tail_q;
    mask_n  = '0;
    if (kill_en) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (valid_q[i] && (addr_q[i] == kill_addr)) valid_n[i] = 1'b0;
      end
    end
    if (pop) begin
      valid_n[head_q] = 1'b0;
      head_n          = PTR_W'(head_q + 1'b1);
    end
    if (push) begin
      valid_n[tail_q] = ~push_kill;
      addr_n[tail_q]  = push_addr;
      data_n[tail_q]  = push_data;
      tail_n          = PTR_W'(tail_q + 1'b1);
    end
    count_n = CNT_W'(count + CNT_W'(push) - CNT_W'(pop));
    ready_n = (count_n < CNT_W'(DEPTH));
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_n[i]) mask_n[addr_n[i]] = 1'b1;
    end
    mask_n[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      addr_q    <= '{default: '0};
      data_q    <= '{default: '0};
      head_q    <= '0;
      tail_q    <= '0;
      count     <= '0;
      ready     <= 1'b0;
      live_mask <= '0;
    end else begin
      valid_q   <= valid_n;
      addr_q    <= addr_n;
      data_q    <= data_n;
      head_q    <= head_n;
      tail_q    <= tail_n;
      count     <= count_n;
      ready     <= ready_n;
      live_mask <= mask_n;
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Merges ALU and LSU retiring writes onto the single register-file write port;
// ALU has priority and squashes older queued writes to the same register.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input logic           clk,
  input logic           rst_n,
  reg_writeback_if.slave wb
);

  logic              alu_req, push, push_kill, pop;
  logic              fifo_empty, head_live;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              we_n;
  logic [ADDR_W-1:0] waddr_n;
  logic [DATA_W-1:0] wdata_n;

  // Writes to r0 neither occupy the port nor enter the queue.
  assign alu_req   = wb.alu_valid && (wb.alu_addr != REG_ZERO);
  assign push      = wb.lsu_valid && wb.lsu_ready && (wb.lsu_addr != REG_ZERO);
  assign push_kill = alu_req && (wb.lsu_addr == wb.alu_addr);
  assign pop       = !alu_req && !fifo_empty;

  reg_writeback_wb_fifo #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_kill(push_kill),
    .push_addr(wb.lsu_addr),
    .push_data(wb.lsu_data),
    .pop      (pop),
    .kill_en  (alu_req),
    .kill_addr(wb.alu_addr),
    .empty    (fifo_empty),
    .head_live(head_live),
    .head_addr(head_addr),
    .head_data(head_data),
    .ready    (wb.lsu_ready),
    .count    (wb.q_count),
    .live_mask(wb.pend_mask)
  );

  // Port arbitration; a killed head frees its slot without a write.
  always_comb begin
    we_n    = 1'b0;
    waddr_n = wb.rf_waddr;
    wdata_n = wb.rf_wdata;
    if (alu_req) begin
      we_n    = 1'b1;
      waddr_n = wb.alu_addr;
      wdata_n = wb.alu_data;
    end else if (pop) begin
      we_n = head_live;
      if (head_live) begin
        waddr_n = head_addr;
        wdata_n = head_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb.rf_we    <= 1'b0;
      wb.rf_waddr <= '0;
      wb.rf_wdata <= '0;
    end else begin
      wb.rf_we    <= we_n;
      wb.rf_waddr <= waddr_n;
      wb.rf_wdata <= wdata_n;
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed self-checking bench for reg_writeback.
module tb_reg_writeback;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_chk;

  reg_writeback_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(3)) bus ();

  reg_writeback #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .wb   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    bus.alu_valid = av;
    bus.alu_addr  = aa;
    bus.alu_data  = ad;
    bus.lsu_valid = lv;
    bus.lsu_addr  = la;
    bus.lsu_data  = ld;
  endtask

  initial begin
    n_pass = 0;
    n_chk  = 0;
    rst_n  = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_we", 32'(bus.rf_we), 32'd0);
    chk("rst_ready", 32'(bus.lsu_ready), 32'd0);
    chk("rst_mask", bus.pend_mask, 32'd0);
    chk("rst_count", 32'(bus.q_count), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rel_ready", 32'(bus.lsu_ready), 32'd1);
    chk("rel_count", 32'(bus.q_count), 32'd0);

    // ALU only
    drive(1, 5'd5, 32'h1234, 0, 0, 0);
    tick();
    chk("alu_we", 32'(bus.rf_we), 32'd1);
    chk("alu_addr", 32'(bus.rf_waddr), 32'd5);
    chk("alu_data", bus.rf_wdata, 32'h1234);
    drive(1, 5'd0, 32'h9999, 0, 0, 0);
    tick();
    chk("alu_r0_we", 32'(bus.rf_we), 32'd0);
    chk("alu_r0_hold_addr", 32'(bus.rf_waddr), 32'd5);
    chk("alu_r0_hold_data", bus.rf_wdata, 32'h1234);

    // Fill queue under ALU pressure
    for (int i = 2; i <= 5; i++) begin
      drive(1, 5'd1, 32'h11, 1, 5'(i), 32'(i * 16'h11));
      tick();
    end
    chk("fill_count", 32'(bus.q_count), 32'd4);
    chk("fill_ready", 32'(bus.lsu_ready), 32'd0);
    chk("fill_mask", bus.pend_mask, 32'h3C);
    chk("fill_alu_addr", 32'(bus.rf_waddr), 32'd1);

    // Full queue refuses r6 even while popping
    drive(0, 0, 0, 1, 5'd6, 32'h66);
    tick();
    chk("drain2_we", 32'(bus.rf_we), 32'd1);
    chk("drain2_addr", 32'(bus.rf_waddr), 32'd2);
    chk("drain2_data", bus.rf_wdata, 32'h22);
    chk("full_no_push_count", 32'(bus.q_count), 32'd3);
    chk("drain_ready", 32'(bus.lsu_ready), 32'd1);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("drain3_addr", 32'(bus.rf_waddr), 32'd3);
    chk("drain3_data", bus.rf_wdata, 32'h33);
    tick();
    chk("drain4_addr", 32'(bus.rf_waddr), 32'd4);
    chk("drain4_data", bus.rf_wdata, 32'h44);
    tick();
    chk("drain5_we", 32'(bus.rf_we), 32'd1);
    chk("drain5_addr", 32'(bus.rf_waddr), 32'd5);
    chk("drain5_data", bus.rf_wdata, 32'h55);
    chk("drain_count", 32'(bus.q_count), 32'd0);
    chk("drain_mask", bus.pend_mask, 32'd0);
    tick();
    chk("idle_we", 32'(bus.rf_we), 32'd0);

    // Kill a queued write by a younger ALU write
    drive(1, 5'd8, 32'h8, 1, 5'd7, 32'hAAAA);
    tick();
    chk("kill_q_count", 32'(bus.q_count), 32'd1);
    chk("kill_q_mask", bus.pend_mask, 32'h80);
    drive(1, 5'd7, 32'hBBBB, 0, 0, 0);
    tick();
    chk("kill_alu_addr", 32'(bus.rf_waddr), 32'd7);
    chk("kill_alu_data", bus.rf_wdata, 32'hBBBB);
    chk("kill_mask", bus.pend_mask, 32'd0);
    chk("kill_slot_kept", 32'(bus.q_count), 32'd1);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("kill_pop_we", 32'(bus.rf_we), 32'd0);
    chk("kill_pop_data", bus.rf_wdata, 32'hBBBB);
    chk("kill_pop_count", 32'(bus.q_count), 32'd0);

    // Same-cycle collision
    drive(1, 5'd9, 32'h2, 1, 5'd9, 32'h1);
    tick();
    chk("coll_addr", 32'(bus.rf_waddr), 32'd9);
    chk("coll_data", bus.rf_wdata, 32'h2);
    chk("coll_count", 32'(bus.q_count), 32'd1);
    chk("coll_mask", bus.pend_mask, 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("coll_pop_we", 32'(bus.rf_we), 32'd0);
    chk("coll_pop_data", bus.rf_wdata, 32'h2);
    chk("coll_pop_count", 32'(bus.q_count), 32'd0);

    // LSU write to r0 is accepted and dropped
    drive(0, 0, 0, 1, 5'd0, 32'hDEAD);
    tick();
    chk("r0_push_count", 32'(bus.q_count), 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("r0_push_we", 32'(bus.rf_we), 32'd0);

    // Async reset with three queued entries
    for (int i = 10; i <= 12; i++) begin
      drive(1, 5'd1, 32'h77, 1, 5'(i), 32'(i));
      tick();
    end
    chk("pre_rst_count", 32'(bus.q_count), 32'd3);
    chk("pre_rst_mask", bus.pend_mask, 32'h1C00);
    #3;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("arst_we", 32'(bus.rf_we), 32'd0);
    chk("arst_addr", 32'(bus.rf_waddr), 32'd0);
    chk("arst_count", 32'(bus.q_count), 32'd0);
    chk("arst_mask", bus.pend_mask, 32'd0);
    chk("arst_ready", 32'(bus.lsu_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_no_write", 32'(bus.rf_we), 32'd0);
    end
    chk("post_rst_ready", 32'(bus.lsu_ready), 32'd1);
    chk("post_rst_count", 32'(bus.q_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Write-side front end of the 32x32 register file: merges retiring writes from the single-cycle ALU path and the variable-latency load/store path into the register file's one write port.
- The ALU path has absolute priority and is never stalled.
- LSU writes are buffered in a small in-order FIFO with a ready/valid handshake.
- Exports a pending-write mask so the decode stage can stall RAW hazards on queued loads.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width (32 registers, r0 hard-wired zero)
- DEPTH, 4, LSU write-queue entries (power of two, >=2)

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- alu_valid  input  1  ALU result retiring this cycle
- alu_addr  input  ADDR_W  ALU destination register
- alu_data  input  DATA_W  ALU result
- lsu_valid  input  1  LSU write request
- lsu_ready  output  1  queue can accept an LSU request
- lsu_addr  input  ADDR_W  LSU destination register
- lsu_data  input  DATA_W  load data
- rf_we  output  1  register-file write enable (registered)
- rf_waddr  output  ADDR_W  register-file write address (registered)
- rf_wdata  output  DATA_W  register-file write data (registered)
- pend_mask  output  32  bit i = a live queued write targets register i
- q_count  output  clog2(DEPTH)+1  queue occupancy

Behaviour:
- Reset (async assert, sync-safe deassert): rf_we=0, rf_waddr=0, rf_wdata=0, q_count=0, all entries invalid, pend_mask=0, lsu_ready=0 while rst_n low. Reset mid-operation discards all queued writes; no write is issued.
- Clock and reset polarity: one clock, clk; reset is asynchronous and active-low, rst_n.
- alu_req = alu_valid & (alu_addr != 0). A write to r0 is not a request, and the port stays free.
- LSU push: lsu_valid & lsu_ready. lsu_ready = (q_count < DEPTH). It depends on occupancy only, so a full queue does not accept a request even in a cycle where it pops.
- A push with lsu_addr==0 completes the handshake but is dropped (not enqueued).
- Port arbitration each cycle, registered into rf_*:
  - alu_req: rf_we=1, rf_waddr=alu_addr, rf_wdata=alu_data. Queue does not pop.
  - else queue non-empty: pop head. If the head is live, rf_we=1 with its addr/data; if killed, rf_we=0. Either way the slot frees.
  - else rf_we=0; rf_waddr and rf_wdata hold their previous values.
- Latency: ALU write appears on rf_* one cycle after alu_valid. An LSU push pops no earlier than the next cycle, so minimum latency is 2 cycles. There is no bypass.
- Ordering: the ALU write is always younger than every queued or same-cycle LSU write.
  - On alu_req, every live entry with addr==alu_addr is killed (valid cleared, slot kept).
  - A same-cycle LSU push to alu_addr is enqueued already-killed.
- Queue: circular buffer; head/tail pointers wrap modulo DEPTH.
  - Simultaneous push and pop leaves q_count unchanged.
  - Push to an empty queue concurrent with alu_req stays queued.
- pend_mask: OR over live entries of one-hot(addr). Bit 0 is always 0. Derived from registered state, so it has no combinational path from inputs.
- Killed entries do not appear in pend_mask.
- rf_we is a one-cycle pulse per write.
- Never two writes in one cycle; the queue never overflows or underflows.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults, REG_ZERO constant, NUM_REGS=32, clog2 helper.
- Sub-module wb_fifo: circular buffer with per-entry valid bit, address-match kill input, and a live-address one-hot OR output.
- Top level holds the arbitration and the output registers.

Test Plan:
- Reset then idle: rst_n=0 → rf_we=0, lsu_ready=0, pend_mask=0. Release → lsu_ready=1, q_count=0.
- ALU only: alu_valid=1, addr=5, data=0x1234 at cycle t → rf_we=1, rf_waddr=5, rf_wdata=0x1234 at t+1. Same stimulus with addr=0 → rf_we=0.
- LSU fill under ALU pressure: alu_valid every cycle to r1 while pushing LSU r2,r3,r4,r5.
  - Expect q_count=4, lsu_ready=0, pend_mask=0x3C.
  - Drop alu_valid → r2..r5 written in order on 4 consecutive cycles; q_count returns to 0.
- Kill: queue holds r7=0xAAAA; alu write r7=0xBBBB.
  - Expect pend_mask bit7 cleared the next cycle.
  - Later pop produces rf_we=0; final rf write to r7 is 0xBBBB only.
- Same-cycle collision: lsu push r9=0x1 and alu r9=0x2 in one cycle → only r9=0x2 is written; the r9 entry pops with rf_we=0.
- Async reset mid-queue: 3 entries queued, assert rst_n between edges → outputs clear immediately; after release, no stale write ever appears.
